// File: rtl/axis_decouple_ctrl_if.sv
// Signal bundle between a partial-reconfiguration manager and the per-region
// decouple controller: request/ack/decouple per region, timeout control, and
// read-only taps of the AXI4S streams seen on the decoupler side.
interface axis_decouple_ctrl_if #(
  parameter int unsigned N_ID         = 2,
  parameter int unsigned N_STRM       = 2,
  parameter int unsigned TIMEOUT_BITS = 16
);

  logic [N_ID-1:0]         dcpl_req;
  logic [N_ID-1:0]         dcpl_ack;
  logic [N_ID-1:0]         decouple;
  logic [TIMEOUT_BITS-1:0] timeout_val;
  logic [N_ID-1:0]         timeout_flag;
  logic [N_ID-1:0]         timeout_clr;
  logic [N_ID*N_STRM-1:0]  mon_tvalid;
  logic [N_ID*N_STRM-1:0]  mon_tready;
  logic [N_ID*N_STRM-1:0]  mon_tlast;

  // Manager side: issues requests, observes the controller.
  modport master (
    output dcpl_req, timeout_val, timeout_clr,
    output mon_tvalid, mon_tready, mon_tlast,
    input  dcpl_ack, decouple, timeout_flag
  );

  // Controller side.
  modport slave (
    input  dcpl_req, timeout_val, timeout_clr,
    input  mon_tvalid, mon_tready, mon_tlast,
    output dcpl_ack, decouple, timeout_flag
  );

endinterface

// File: rtl/axis_decouple_ctrl.sv
// Per-region decouple sequencer for partial reconfiguration. A region is only
// decoupled once all its monitored streams sit at a packet boundary, or when
// the drain timeout expires. decouple/ack are decoded straight from the state
// register, so no input reaches them combinationally.
module axis_decouple_ctrl #(
  parameter int unsigned N_ID         = 2,
  parameter int unsigned N_STRM       = 2,
  parameter int unsigned TIMEOUT_BITS = 16
) (
  input  logic                aclk,
  input  logic                areset,
  axis_decouple_ctrl_if.slave bus
);

  localparam int unsigned N_MON = N_ID * N_STRM;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_DECOUPLED = 2'd2,
    ST_RECOUPLE  = 2'd3
  } state_e;

  logic [N_MON-1:0]        hs;
  logic [N_MON-1:0]        next_open;
  logic [N_MON-1:0]        open_q;
  logic [N_MON-1:0]        open_d;
  logic [N_ID-1:0]         idle;

  state_e                  state_q [N_ID];
  state_e                  state_d [N_ID];
  logic [TIMEOUT_BITS-1:0] cnt_q   [N_ID];
  logic [TIMEOUT_BITS-1:0] cnt_d   [N_ID];

  logic [N_ID-1:0]         timeout_flag_q;
  logic [N_ID-1:0]         timeout_flag_d;
  logic [N_ID-1:0]         timeout_set;

  logic                    tmo_en;
  logic [TIMEOUT_BITS-1:0] tmo_last;

  logic [N_ID-1:0]         decouple_w;
  logic [N_ID-1:0]         ack_w;

  assign tmo_en   = |bus.timeout_val;
  assign tmo_last = bus.timeout_val - 1'b1;

  // Packet trackers: post-handshake "inside a packet" view of each stream.
  always_comb begin
    hs        = bus.mon_tvalid & bus.mon_tready;
    next_open = (hs & ~bus.mon_tlast) | (~hs & open_q);
  end

  // Region idle uses the post-update tracker, so a closing tlast beat or a
  // single-beat packet in the current cycle already counts as a boundary.
  always_comb begin
    idle = '0;
    for (int unsigned i = 0; i < N_ID; i++) begin
      idle[i] = ~|next_open[i*N_STRM +: N_STRM];
    end
  end

  // Tracker next value; RECOUPLE discards whatever truncated packet remains.
  always_comb begin
    open_d = next_open;
    for (int unsigned i = 0; i < N_ID; i++) begin
      if (state_q[i] == ST_RECOUPLE) begin
        open_d[i*N_STRM +: N_STRM] = '0;
      end
    end
  end

  // Per-region next state, drain counter and timeout flag update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_set = '0;
    for (int unsigned i = 0; i < N_ID; i++) begin
      unique case (state_q[i])
        ST_RUN: begin
          if (bus.dcpl_req[i]) begin
            state_d[i] = ST_DRAIN;
            cnt_d[i]   = '0;
          end
        end
        ST_DRAIN: begin
          // Abort beats idle, idle beats timeout (so no flag on a tie).
          if (!bus.dcpl_req[i]) begin
            state_d[i] = ST_RUN;
          end else if (idle[i]) begin
            state_d[i] = ST_DECOUPLED;
          end else if (tmo_en && (cnt_q[i] == tmo_last)) begin
            state_d[i]     = ST_DECOUPLED;
            timeout_set[i] = 1'b1;
          end else if (cnt_q[i] != '1) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        ST_DECOUPLED: begin
          if (!bus.dcpl_req[i]) begin
            state_d[i] = ST_RECOUPLE;
          end
        end
        ST_RECOUPLE: begin
          state_d[i] = ST_RUN;
        end
        default: begin
          state_d[i] = ST_RUN;
        end
      endcase
    end
    timeout_flag_d = (timeout_flag_q | timeout_set) & ~bus.timeout_clr;
  end

  // Output decode from the registered state only.
  always_comb begin
    decouple_w = '0;
    ack_w      = '0;
    for (int unsigned i = 0; i < N_ID; i++) begin
      decouple_w[i] = (state_q[i] == ST_DECOUPLED) || (state_q[i] == ST_RECOUPLE);
      ack_w[i]      = (state_q[i] == ST_DECOUPLED);
    end
  end

  assign bus.decouple     = decouple_w;
  assign bus.dcpl_ack     = ack_w;
  assign bus.timeout_flag = timeout_flag_q;

  // State, counters, trackers and flags; async reset returns every region to RUN.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int unsigned i = 0; i < N_ID; i++) begin
        state_q[i] <= ST_RUN;
        cnt_q[i]   <= '0;
      end
      open_q         <= '0;
      timeout_flag_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_ID; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      open_q         <= open_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

endmodule

// File: tb/tb_axis_decouple_ctrl.sv
// Bench for axis_decouple_ctrl: vector table, hand-written multi-cycle
// sequences, then randomized traffic against a packet-level reference model.
module tb_axis_decouple_ctrl;

  localparam int unsigned N_ID   = 2;
  localparam int unsigned N_STRM = 2;
  localparam int unsigned TB     = 16;
  localparam int unsigned N_MON  = N_ID * N_STRM;

  logic aclk;
  logic areset;

  axis_decouple_ctrl_if #(.N_ID(N_ID), .N_STRM(N_STRM), .TIMEOUT_BITS(TB)) bus ();

  axis_decouple_ctrl #(.N_ID(N_ID), .N_STRM(N_STRM), .TIMEOUT_BITS(TB)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [3:0]  tv;
    logic [3:0]  tr;
    logic [3:0]  tl;
    logic [15:0] tmo;
    logic [1:0]  clr;
    logic [1:0]  e_dec;
    logic [1:0]  e_ack;
    logic [1:0]  e_flag;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] req, input logic [3:0] tv, input logic [3:0] tr,
                              input logic [3:0] tl, input logic [15:0] tmo, input logic [1:0] clr,
                              input logic [1:0] e_dec, input logic [1:0] e_ack, input logic [1:0] e_flag);
    vec_t v;
    v.req = req; v.tv = tv; v.tr = tr; v.tl = tl; v.tmo = tmo; v.clr = clr;
    v.e_dec = e_dec; v.e_ack = e_ack; v.e_flag = e_flag;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic [1:0] req, input logic [3:0] tv, input logic [3:0] tr,
                       input logic [3:0] tl, input logic [15:0] tmo, input logic [1:0] clr);
    bus.dcpl_req    = req;
    bus.mon_tvalid  = tv;
    bus.mon_tready  = tr;
    bus.mon_tlast   = tl;
    bus.timeout_val = tmo;
    bus.timeout_clr = clr;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    drive(2'b00, 4'h0, 4'h0, 4'h0, 16'd0, 2'b00);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
  endtask

  // Reference model: per-stream beat counts inside the current packet, and per
  // region a drain age (-1 when not draining) plus decoupled/recoupling bits.
  int beats  [N_MON];
  int age    [N_ID];
  bit m_dec  [N_ID];
  bit m_rec  [N_ID];
  bit m_flag [N_ID];

  function automatic void model_reset();
    for (int k = 0; k < N_MON; k++) beats[k] = 0;
    for (int i = 0; i < N_ID; i++) begin
      age[i] = -1; m_dec[i] = 0; m_rec[i] = 0; m_flag[i] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int i = 0; i < N_ID; i++) begin
      int nb [N_STRM];
      bit quiet = 1;
      bit set   = 0;
      int tmo   = int'(bus.timeout_val);
      for (int j = 0; j < N_STRM; j++) begin
        int k = i * N_STRM + j;
        if (bus.mon_tvalid[k] && bus.mon_tready[k]) nb[j] = bus.mon_tlast[k] ? 0 : beats[k] + 1;
        else nb[j] = beats[k];
        if (nb[j] != 0) quiet = 0;
      end
      if (m_rec[i]) begin
        m_rec[i] = 0;
        for (int j = 0; j < N_STRM; j++) nb[j] = 0;
      end else if (m_dec[i]) begin
        if (!bus.dcpl_req[i]) begin m_dec[i] = 0; m_rec[i] = 1; end
      end else if (age[i] >= 0) begin
        if (!bus.dcpl_req[i]) age[i] = -1;
        else if (quiet) begin m_dec[i] = 1; age[i] = -1; end
        else if (tmo != 0 && age[i] == tmo - 1) begin m_dec[i] = 1; age[i] = -1; set = 1; end
        else if (age[i] < (1 << TB) - 1) age[i]++;
      end else if (bus.dcpl_req[i]) begin
        age[i] = 0;
      end
      for (int j = 0; j < N_STRM; j++) beats[i*N_STRM+j] = nb[j];
      if (bus.timeout_clr[i]) m_flag[i] = 0;
      else if (set) m_flag[i] = 1;
    end
  endfunction

  function automatic logic [1:0] m_dec_v();
    logic [1:0] v;
    for (int i = 0; i < N_ID; i++) v[i] = m_dec[i] | m_rec[i];
    return v;
  endfunction

  function automatic logic [1:0] m_ack_v();
    logic [1:0] v;
    for (int i = 0; i < N_ID; i++) v[i] = m_dec[i];
    return v;
  endfunction

  function automatic logic [1:0] m_flag_v();
    logic [1:0] v;
    for (int i = 0; i < N_ID; i++) v[i] = m_flag[i];
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- vector table (region 1 stays idle throughout) ----
    //   req    tv       tr       tl       tmo     clr    | dec    ack    flag
    // mid-packet drain completed by a tlast beat
    add(2'b00, 4'b0010, 4'b0010, 4'b0000, 16'd100, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 4'b0010, 4'b0010, 4'b0000, 16'd100, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 4'b0010, 4'b0010, 4'b0000, 16'd100, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int r = 0; r < 5; r++)
      add(2'b01, 4'b0000, 4'b0000, 4'b0000, 16'd100, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 4'b0010, 4'b0010, 4'b0010, 16'd100, 2'b00, 2'b01, 2'b01, 2'b00);
    add(2'b01, 4'b0000, 4'b0000, 4'b0000, 16'd100, 2'b00, 2'b01, 2'b01, 2'b00);
    add(2'b00, 4'b0000, 4'b0000, 4'b0000, 16'd100, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00, 4'b0000, 4'b0000, 4'b0000, 16'd100, 2'b00, 2'b00, 2'b00, 2'b00);
    // abort during an open packet
    add(2'b00, 4'b0001, 4'b0001, 4'b0000, 16'd100, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int r = 0; r < 3; r++)
      add(2'b01, 4'b0000, 4'b0000, 4'b0000, 16'd100, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 4'b0000, 4'b0000, 4'b0000, 16'd100, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 4'b0001, 4'b0001, 4'b0001, 16'd100, 2'b00, 2'b00, 2'b00, 2'b00);
    // idle and timeout in the same cycle: decouple without flag
    add(2'b00, 4'b0001, 4'b0001, 4'b0000, 16'd1,   2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 4'b0000, 4'b0000, 4'b0000, 16'd1,   2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 4'b0001, 4'b0001, 4'b0001, 16'd1,   2'b00, 2'b01, 2'b01, 2'b00);
    add(2'b00, 4'b0000, 4'b0000, 4'b0000, 16'd1,   2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00, 4'b0000, 4'b0000, 4'b0000, 16'd1,   2'b00, 2'b00, 2'b00, 2'b00);
    // request drop and idle together: abort wins
    add(2'b00, 4'b0001, 4'b0001, 4'b0000, 16'd1,   2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 4'b0000, 4'b0000, 4'b0000, 16'd1,   2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 4'b0001, 4'b0001, 4'b0001, 16'd1,   2'b00, 2'b00, 2'b00, 2'b00);
    // clear and set in the same cycle: flag stays 0; truncated packet left open
    add(2'b00, 4'b0001, 4'b0001, 4'b0000, 16'd1,   2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 4'b0000, 4'b0000, 4'b0000, 16'd1,   2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 4'b0000, 4'b0000, 4'b0000, 16'd1,   2'b01, 2'b01, 2'b01, 2'b00);
    add(2'b00, 4'b0000, 4'b0000, 4'b0000, 16'd1,   2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00, 4'b0000, 4'b0000, 4'b0000, 16'd1,   2'b00, 2'b00, 2'b00, 2'b00);
    // recouple dropped the truncated packet: clean decouple, no flag
    add(2'b01, 4'b0000, 4'b0000, 4'b0000, 16'd1,   2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 4'b0000, 4'b0000, 4'b0000, 16'd1,   2'b00, 2'b01, 2'b01, 2'b00);
    add(2'b00, 4'b0000, 4'b0000, 4'b0000, 16'd1,   2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00, 4'b0000, 4'b0000, 4'b0000, 16'd1,   2'b00, 2'b00, 2'b00, 2'b00);
    // plain timeout sets a sticky flag, cleared later in RUN
    add(2'b00, 4'b0001, 4'b0001, 4'b0000, 16'd1,   2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 4'b0000, 4'b0000, 4'b0000, 16'd1,   2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 4'b0000, 4'b0000, 4'b0000, 16'd1,   2'b00, 2'b01, 2'b01, 2'b01);
    add(2'b00, 4'b0000, 4'b0000, 4'b0000, 16'd1,   2'b00, 2'b01, 2'b00, 2'b01);
    add(2'b00, 4'b0000, 4'b0000, 4'b0000, 16'd1,   2'b00, 2'b00, 2'b00, 2'b01);
    add(2'b00, 4'b0000, 4'b0000, 4'b0000, 16'd1,   2'b01, 2'b00, 2'b00, 2'b00);

    areset = 1'b0;
    drive(2'b00, 4'h0, 4'h0, 4'h0, 16'd0, 2'b00);
    #2 areset = 1'b1;
    #1;
    chk("reset_decouple", bus.decouple, 2'b00);
    chk("reset_ack", bus.dcpl_ack, 2'b00);
    chk("reset_flag", bus.timeout_flag, 2'b00);
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;

    // ---- table ----
    foreach (vecs[n]) begin
      drive(vecs[n].req, vecs[n].tv, vecs[n].tr, vecs[n].tl, vecs[n].tmo, vecs[n].clr);
      @(negedge aclk);
      chk($sformatf("vec%0d_decouple", n), bus.decouple, vecs[n].e_dec);
      chk($sformatf("vec%0d_ack", n), bus.dcpl_ack, vecs[n].e_ack);
      chk($sformatf("vec%0d_flag", n), bus.timeout_flag, vecs[n].e_flag);
    end

    // ---- idle-region latency: 2 cycles in, ack then decouple out ----
    do_reset();
    drive(2'b01, 4'h0, 4'h0, 4'h0, 16'd0, 2'b00);
    @(negedge aclk);
    chk("lat_drain_dec", bus.decouple, 2'b00);
    @(negedge aclk);
    chk("lat_in_dec", bus.decouple, 2'b01);
    chk("lat_in_ack", bus.dcpl_ack, 2'b01);
    repeat (3) @(negedge aclk);
    bus.dcpl_req = 2'b00;
    @(negedge aclk);
    chk("lat_out_ack", bus.dcpl_ack, 2'b00);
    chk("lat_out_dec_hold", bus.decouple, 2'b01);
    @(negedge aclk);
    chk("lat_out_dec", bus.decouple, 2'b00);

    // ---- stalled mid-packet, timeout 8: decouple 9 edges after request ----
    begin
      int seen = 0;
      drive(2'b00, 4'b0001, 4'b0001, 4'b0000, 16'd8, 2'b00);
      @(negedge aclk);
      drive(2'b01, 4'h0, 4'h0, 4'h0, 16'd8, 2'b00);
      for (int c = 1; c <= 20 && seen == 0; c++) begin
        @(negedge aclk);
        if (bus.decouple[0]) seen = c;
      end
      chk("tmo_latency", seen, 9);
      chk("tmo_flag_set", bus.timeout_flag, 2'b01);
      bus.timeout_clr = 2'b01;
      @(negedge aclk);
      bus.timeout_clr = 2'b00;
      chk("tmo_flag_clr", bus.timeout_flag, 2'b00);
      chk("tmo_still_dec", bus.dcpl_ack, 2'b01);
      drive(2'b00, 4'h0, 4'h0, 4'h0, 16'd0, 2'b00);
      @(negedge aclk);
      @(negedge aclk);
      chk("tmo_recoupled", bus.decouple, 2'b00);
    end

    // ---- region 1 decouples while region 0 keeps streaming ----
    drive(2'b10, 4'b0011, 4'b0011, 4'b0000, 16'd0, 2'b00);
    for (int c = 1; c <= 6; c++) begin
      @(negedge aclk);
      chk($sformatf("indep_r0_c%0d", c), bus.decouple[0], 1'b0);
      if (c == 1) chk("indep_r1_drain", bus.decouple[1], 1'b0);
      if (c == 2) begin
        chk("indep_r1_dec", bus.decouple[1], 1'b1);
        chk("indep_r1_ack", bus.dcpl_ack, 2'b10);
      end
      bus.mon_tlast = (c % 3 == 2) ? 4'b0011 : 4'b0000;
    end
    drive(2'b00, 4'h0, 4'h0, 4'h0, 16'd0, 2'b00);
    @(negedge aclk);
    @(negedge aclk);

    // ---- async reset while decoupled, then single-beat packet + request ----
    do_reset();
    drive(2'b00, 4'b0001, 4'b0001, 4'b0000, 16'd2, 2'b00);
    @(negedge aclk);
    drive(2'b01, 4'h0, 4'h0, 4'h0, 16'd2, 2'b00);
    repeat (3) @(negedge aclk);
    chk("arst_pre_dec", bus.decouple, 2'b01);
    chk("arst_pre_flag", bus.timeout_flag, 2'b01);
    #2 areset = 1'b1;
    #1;
    chk("arst_dec", bus.decouple, 2'b00);
    chk("arst_ack", bus.dcpl_ack, 2'b00);
    chk("arst_flag", bus.timeout_flag, 2'b00);
    drive(2'b00, 4'h0, 4'h0, 4'h0, 16'd0, 2'b00);
    @(negedge aclk);
    areset = 1'b0;
    drive(2'b00, 4'b0001, 4'b0001, 4'b0001, 16'd0, 2'b00);
    @(negedge aclk);
    drive(2'b01, 4'h0, 4'h0, 4'h0, 16'd0, 2'b00);
    @(negedge aclk);
    chk("arst_post_drain", bus.decouple, 2'b00);
    @(negedge aclk);
    chk("arst_post_dec", bus.decouple, 2'b01);
    chk("arst_post_ack", bus.dcpl_ack, 2'b01);

    // ---- randomized traffic against the reference model ----
    do_reset();
    model_reset();
    begin
      logic [1:0]  req = 2'b00;
      logic [15:0] tmo = 16'd0;
      int          tmo_tab [6] = '{0, 1, 2, 3, 6, 15};
      for (int cyc = 0; cyc < 3000; cyc++) begin
        logic [3:0] tv, tr, tl;
        logic [1:0] clr;
        chk($sformatf("rnd%0d_decouple", cyc), bus.decouple, m_dec_v());
        chk($sformatf("rnd%0d_ack", cyc), bus.dcpl_ack, m_ack_v());
        chk($sformatf("rnd%0d_flag", cyc), bus.timeout_flag, m_flag_v());
        if (cyc % 200 == 0) tmo = 16'(tmo_tab[$urandom_range(0, 5)]);
        for (int i = 0; i < N_ID; i++)
          if ($urandom_range(0, 11) == 0) req[i] = ~req[i];
        tv = 4'($urandom);
        tr = 4'($urandom);
        for (int k = 0; k < N_MON; k++) tl[k] = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 7) < 3) tv = 4'h0;
        for (int i = 0; i < N_ID; i++) clr[i] = ($urandom_range(0, 15) == 0);
        drive(req, tv, tr, tl, tmo, clr);
        model_step();
        @(negedge aclk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
